// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: word/memory sizes, access-size
// encodings, FSM state encoding and the alignment rule used by the lane logic.
package load_store_unit_pkg;

  localparam int WORD_LEN     = 32;
  localparam int DataMEM_SIZE = 1024;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic {
    LSU_IDLE  = 1'b0,
    LSU_WRITE = 1'b1
  } lsu_state_e;

  // Half needs an even byte address, word needs a word-aligned one; 2'b11 is never legal.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      LSU_SIZE_B: bad = 1'b0;
      LSU_SIZE_H: bad = lane[0];
      LSU_SIZE_W: bad = (lane != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Little-endian lane steering: extracts/extends load data from a memory word and
// merges sub-word store data into a memory word for read-modify-write.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]          i_size,
  input  logic [1:0]          i_lane,
  input  logic                i_unsigned,
  input  logic [WORD_LEN-1:0] i_mem_word,
  input  logic [15:0]         i_st_data,
  output logic [WORD_LEN-1:0] o_ld_data,
  output logic [WORD_LEN-1:0] o_st_merge,
  output logic                o_misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_bit;

  always_comb begin
    case (i_lane)
      2'd0:    byte_sel = i_mem_word[7:0];
      2'd1:    byte_sel = i_mem_word[15:8];
      2'd2:    byte_sel = i_mem_word[23:16];
      default: byte_sel = i_mem_word[31:24];
    endcase
    half_sel = i_lane[1] ? i_mem_word[31:16] : i_mem_word[15:0];
  end

  always_comb begin
    sign_bit  = 1'b0;
    o_ld_data = i_mem_word;
    case (i_size)
      LSU_SIZE_B: begin
        sign_bit  = ~i_unsigned & byte_sel[7];
        o_ld_data = {{24{sign_bit}}, byte_sel};
      end
      LSU_SIZE_H: begin
        sign_bit  = ~i_unsigned & half_sel[15];
        o_ld_data = {{16{sign_bit}}, half_sel};
      end
      default: o_ld_data = i_mem_word;
    endcase
  end

  // Word stores bypass the merge path, so only byte and half lanes are replaced.
  always_comb begin
    o_st_merge = i_mem_word;
    case (i_size)
      LSU_SIZE_B: begin
        case (i_lane)
          2'd0:    o_st_merge[7:0]   = i_st_data[7:0];
          2'd1:    o_st_merge[15:8]  = i_st_data[7:0];
          2'd2:    o_st_merge[23:16] = i_st_data[7:0];
          default: o_st_merge[31:24] = i_st_data[7:0];
        endcase
      end
      LSU_SIZE_H: begin
        if (i_lane[1]) o_st_merge[31:16] = i_st_data;
        else           o_st_merge[15:0]  = i_st_data;
      end
      default: o_st_merge = i_mem_word;
    endcase
  end

  assign o_misaligned = lsu_misaligned(i_size, i_lane);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core execute stage and the word-only data memory.
// Loads complete in one cycle; sub-word stores read-modify-write over two cycles.
module load_store_unit #(
  parameter int WORD_LEN  = load_store_unit_pkg::WORD_LEN,
  parameter int MEM_DEPTH = load_store_unit_pkg::DataMEM_SIZE,
  parameter int ADDR_W    = $clog2(MEM_DEPTH) + 2
) (
  input  logic                i_CLK,
  input  logic                i_RSTN,
  input  logic                i_Req,
  input  logic                i_We,
  input  logic [1:0]          i_Size,
  input  logic                i_Unsigned,
  input  logic [ADDR_W-1:0]   i_Addr,
  input  logic [WORD_LEN-1:0] i_WData,
  output logic                o_Ready,
  output logic                o_RValid,
  output logic [WORD_LEN-1:0] o_RData,
  output logic                o_Err,
  output logic                o_MemRead,
  output logic                o_MemWrite,
  output logic [ADDR_W-3:0]   o_MemAddr,
  output logic [WORD_LEN-1:0] o_MemWData,
  input  logic [WORD_LEN-1:0] i_MemRData
);
  import load_store_unit_pkg::*;

  // Handshake: a request is taken when i_Req && o_Ready; an unaccepted request
  // must be held by the core, and o_RValid/o_Err are single-cycle pulses.
  lsu_state_e          state_q, state_d;
  logic [ADDR_W-3:0]   r_addr_q, r_addr_d;
  logic [WORD_LEN-1:0] r_merge_q, r_merge_d;
  logic [WORD_LEN-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;

  logic                accept;
  logic [ADDR_W-3:0]   word_addr;
  logic [WORD_LEN-1:0] ld_data;
  logic [WORD_LEN-1:0] st_merge;
  logic                misaligned;

  lsu_lane_align u_lane_align (
    .i_size       (i_Size),
    .i_lane       (i_Addr[1:0]),
    .i_unsigned   (i_Unsigned),
    .i_mem_word   (i_MemRData),
    .i_st_data    (i_WData[15:0]),
    .o_ld_data    (ld_data),
    .o_st_merge   (st_merge),
    .o_misaligned (misaligned)
  );

  assign o_Ready   = (state_q == LSU_IDLE);
  assign accept    = i_Req && o_Ready;
  assign word_addr = i_Addr[ADDR_W-1:2];

  always_comb begin
    state_d    = state_q;
    r_addr_d   = r_addr_q;
    r_merge_d  = r_merge_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    o_MemRead  = 1'b0;
    o_MemWrite = 1'b0;
    o_MemAddr  = '0;
    o_MemWData = '0;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else if (!i_We) begin
            o_MemRead = 1'b1;
            o_MemAddr = word_addr;
            rdata_d   = ld_data;
            rvalid_d  = 1'b1;
          end else if (i_Size == LSU_SIZE_W) begin
            o_MemWrite = 1'b1;
            o_MemAddr  = word_addr;
            o_MemWData = i_WData;
          end else begin
            // Read half of the RMW: capture the merged word, write it next cycle.
            o_MemRead = 1'b1;
            o_MemAddr = word_addr;
            r_addr_d  = word_addr;
            r_merge_d = st_merge;
            state_d   = LSU_WRITE;
          end
        end
      end
      LSU_WRITE: begin
        o_MemWrite = 1'b1;
        o_MemAddr  = r_addr_q;
        o_MemWData = r_merge_q;
        state_d    = LSU_IDLE;
      end
    endcase
  end

  // Async reset drops state to IDLE immediately, so a pending RMW write never fires.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q   <= LSU_IDLE;
      r_addr_q  <= '0;
      r_merge_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_addr_q  <= r_addr_d;
      r_merge_q <= r_merge_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign o_RValid = rvalid_q;
  assign o_RData  = rdata_q;
  assign o_Err    = err_q;

endmodule
